// File: rtl/mux_sel_ctrl_if.sv
// mux_sel_ctrl_if
//   Groups the board-level pins of the select controller into one bundle.
//   The bench side (master) drives the keys and switches. The controller
//   side (slave) drives the mux outputs and the status LEDs.
//   KEY  [3:0] : KEY[0] async active-low reset, KEY[1] toggle, KEY[2] mode
//   SW   [9:0] : SW[0] data x, SW[1] data y
//   mux_s      : registered select (0 = x, 1 = y)
//   mux_x/y    : registered data
//   LEDR [9:0] : {mux_s, auto, 6'b0, mux_y, mux_x}
interface mux_sel_ctrl_if;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic       mux_s;
  logic       mux_x;
  logic       mux_y;
  logic [9:0] LEDR;

  modport master (output KEY, output SW,
                  input  mux_s, input mux_x, input mux_y, input LEDR);
  modport slave  (input  KEY, input  SW,
                  output mux_s, output mux_x, output mux_y, output LEDR);
endinterface

// File: rtl/mux_sel_ctrl.sv
// mux_sel_ctrl
//   Drives the select, x and y inputs of a downstream 2:1 mux from the board
//   keys and switches. In manual mode, the toggle button flips the select.
//   In auto mode, the select flips every AUTO_PERIOD cycles. The mode button
//   switches between the two modes.
//   Build option: define MUX_SEL_AUTO_EN to include auto mode, the period
//   counter and the KEY[2] path. Without it, KEY[2] is ignored and LEDR[8]
//   reads 0.
// Ports
//   CLOCK_50 : system clock, rising edge
//   bus      : mux_sel_ctrl_if.slave (KEY[0] is the async active-low reset)
// Parameters
//   DEBOUNCE_CYCLES : stable cycles needed to accept a button change (>= 2)
//   AUTO_PERIOD     : cycles between select toggles in auto mode (>= 2)
module mux_sel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_PERIOD     = 25000000
) (
  input logic           CLOCK_50,
  mux_sel_ctrl_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
`ifdef MUX_SEL_AUTO_EN
  localparam int NB = 2;
  localparam int PW = $clog2(AUTO_PERIOD);
`else
  localparam int NB = 1;
`endif

`ifdef MUX_SEL_AUTO_EN
  typedef enum logic [1:0] {
    MAN_S0  = 2'b00,
    MAN_S1  = 2'b01,
    AUTO_S0 = 2'b10,
    AUTO_S1 = 2'b11
  } state_t;
`else
  typedef enum logic [1:0] {
    MAN_S0 = 2'b00,
    MAN_S1 = 2'b01
  } state_t;
`endif

  logic          rst_n;
  logic [NB-1:0] btn_pin;
  logic [NB-1:0] btn_s1, btn_s2;
  logic [NB-1:0] btn_lvl, btn_lvl_d;
  logic [NB-1:0] btn_armed;
  logic [NB-1:0] btn_press;
  logic [DW-1:0] btn_cnt [NB];
  logic [1:0]    sync_ready;
  logic [1:0]    sw_s1, sw_s2;
  logic          mux_x_q, mux_y_q;
  logic          tog_press;
  logic          auto_flag;
  logic          mux_s_int;
  logic          unused_pins;
  state_t        state_q, state_d;

  assign rst_n      = bus.KEY[0];
  assign btn_pin[0] = bus.KEY[1];
  assign tog_press  = btn_press[0];

`ifdef MUX_SEL_AUTO_EN
  logic          mode_press;
  logic [PW-1:0] period_q, period_d;
  assign btn_pin[1]  = bus.KEY[2];
  assign mode_press  = btn_press[1];
  assign unused_pins = ^{bus.KEY[3], bus.SW[9:2]};
`else
  assign unused_pins = ^{bus.KEY[3:2], bus.SW[9:2]};
`endif

  // sync_ready marks when btn_s2 first carries a sampled pin value rather
  // than the reset value. A button becomes armed only after it has been
  // seen released. As a result, a button held down through reset produces
  // no press until it is released and pressed again.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1     <= '1;
      btn_s2     <= '1;
      btn_lvl    <= '1;
      btn_lvl_d  <= '1;
      btn_armed  <= '0;
      sync_ready <= '0;
      for (int i = 0; i < NB; i++) btn_cnt[i] <= '0;
    end else begin
      btn_s1     <= btn_pin;
      btn_s2     <= btn_s1;
      btn_lvl_d  <= btn_lvl;
      sync_ready <= {sync_ready[0], 1'b1};
      for (int i = 0; i < NB; i++) begin
        if (sync_ready[1] && btn_s2[i]) btn_armed[i] <= 1'b1;
        if (btn_s2[i] == btn_lvl[i]) begin
          btn_cnt[i] <= '0;
        end else if (btn_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          btn_lvl[i] <= btn_s2[i];
          btn_cnt[i] <= '0;
        end else begin
          btn_cnt[i] <= btn_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A press is the accepted level falling from 1 to 0. Releases are ignored.
  assign btn_press = btn_armed & btn_lvl_d & ~btn_lvl;

  // The data switches need no debouncing. They pass through two sync flops
  // and one output register.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      mux_x_q <= 1'b0;
      mux_y_q <= 1'b0;
    end else begin
      sw_s1   <= bus.SW[1:0];
      sw_s2   <= sw_s1;
      mux_x_q <= sw_s2[0];
      mux_y_q <= sw_s2[1];
    end
  end

  // State register. The period counter lives with the state so that it is
  // cleared on every entry to auto mode.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MAN_S0;
`ifdef MUX_SEL_AUTO_EN
      period_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
`ifdef MUX_SEL_AUTO_EN
      period_q <= period_d;
`endif
    end
  end

  // Next-state logic. A mode press takes priority over both a toggle press
  // and the auto terminal count. The period counter defaults to 0, which
  // covers entry to auto, wrap-around and all manual states.
  always_comb begin
    state_d  = state_q;
`ifdef MUX_SEL_AUTO_EN
    period_d = '0;
    case (state_q)
      MAN_S0:  if (mode_press) state_d = AUTO_S0;
               else if (tog_press) state_d = MAN_S1;
      MAN_S1:  if (mode_press) state_d = AUTO_S1;
               else if (tog_press) state_d = MAN_S0;
      AUTO_S0: if (mode_press) state_d = MAN_S0;
               else if (period_q == PW'(AUTO_PERIOD - 1)) state_d = AUTO_S1;
               else period_d = period_q + 1'b1;
      AUTO_S1: if (mode_press) state_d = MAN_S1;
               else if (period_q == PW'(AUTO_PERIOD - 1)) state_d = AUTO_S0;
               else period_d = period_q + 1'b1;
      default: state_d = MAN_S0;
    endcase
`else
    case (state_q)
      MAN_S0:  if (tog_press) state_d = MAN_S1;
      MAN_S1:  if (tog_press) state_d = MAN_S0;
      default: state_d = MAN_S0;
    endcase
`endif
  end

`ifdef MUX_SEL_AUTO_EN
  assign mux_s_int = (state_q == MAN_S1) || (state_q == AUTO_S1);
  assign auto_flag = (state_q == AUTO_S0) || (state_q == AUTO_S1);
`else
  assign mux_s_int = (state_q == MAN_S1);
  assign auto_flag = 1'b0;
`endif

  assign bus.mux_s = mux_s_int;
  assign bus.mux_x = mux_x_q;
  assign bus.mux_y = mux_y_q;
  assign bus.LEDR  = {mux_s_int, auto_flag, 6'b000000, mux_y_q, mux_x_q};

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// tb_mux_sel_ctrl
//   Directed bench for mux_sel_ctrl with DEBOUNCE_CYCLES=4 and AUTO_PERIOD=8.
//   Each expected output word is queued with the cycle at which it is due.
//   The word is then compared on the falling edge of that cycle.
//   Expected word layout: {mux_s, mux_x, mux_y, LEDR[9:0]}.
module tb_mux_sel_ctrl;
  localparam int DEB = 4;
  localparam int PER = 8;

  typedef struct {
    string      tag;
    int         due;
    logic [12:0] val;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t sb[$];
  logic [12:0] observed;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux_sel_ctrl_if bus ();

  mux_sel_ctrl #(.DEBOUNCE_CYCLES(DEB), .AUTO_PERIOD(PER)) dut (
    .CLOCK_50(clk),
    .bus     (bus.slave)
  );

  assign observed = {bus.mux_s, bus.mux_x, bus.mux_y, bus.LEDR};

  function automatic logic [12:0] mk(input logic s, input logic a,
                                     input logic x, input logic y);
    return {s, x, y, s, a, 6'b000000, y, x};
  endfunction

  task automatic applyStimulus(input string tag, input int dly, input logic [12:0] v);
    exp_t e;
    e.tag = tag;
    e.due = cyc + dly;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        compared++;
        assert (observed === sb[i].val) else begin
          mismatched++;
          $error("[TB] FAIL %s cycle %0d: observed %h expected %h",
                 sb[i].tag, cyc, observed, sb[i].val);
        end
        sb.delete(i);
      end
    end
  endtask

  // Advance n cycles, checking due entries on each falling edge. Inputs
  // change 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.KEY = 4'b1111;
    bus.SW  = 10'b0000000001;
    #2 bus.KEY[0] = 1'b0;
    @(posedge clk);
    #1;

    // reset state and switch latency
    applyStimulus("reset_idle", 0, mk(0, 0, 0, 0));
    tick(3);
    bus.KEY[0] = 1'b1;
    applyStimulus("sw_latency", 3, mk(0, 0, 1, 0));
    tick(6);

    // a bouncing toggle button never reaches the debounce count
    bus.KEY[1] = 1'b0;
    applyStimulus("bounce_ignored", 14, mk(0, 0, 1, 0));
    tick(2); bus.KEY[1] = 1'b1;
    tick(1); bus.KEY[1] = 1'b0;
    tick(2); bus.KEY[1] = 1'b1;
    tick(14);

    // a clean toggle press takes effect exactly DEB+3 cycles after the fall
    bus.KEY[1] = 1'b0;
    applyStimulus("toggle_early", DEB + 2, mk(0, 0, 1, 0));
    applyStimulus("toggle_exact", DEB + 3, mk(1, 0, 1, 0));
    tick(10);
    bus.KEY[1] = 1'b1;
    applyStimulus("release_quiet", 12, mk(1, 0, 1, 0));
    tick(13);

    // swap data. The unused switch bits must not show on LEDR.
    bus.SW = 10'h3FE;
    applyStimulus("sw_change", 3, mk(1, 0, 0, 1));
    tick(5);

`ifdef MUX_SEL_AUTO_EN
    // mode press from MAN_S1, then auto toggling every PER cycles.
    // A toggle press during auto is ignored.
    bus.KEY[2] = 1'b0;
    applyStimulus("mode_early", 6,  mk(1, 0, 0, 1));
    applyStimulus("auto_entry", 7,  mk(1, 1, 0, 1));
    applyStimulus("auto_hold",  14, mk(1, 1, 0, 1));
    applyStimulus("auto_tog1",  15, mk(0, 1, 0, 1));
    applyStimulus("auto_togkey",16, mk(0, 1, 0, 1));
    applyStimulus("auto_hold2", 22, mk(0, 1, 0, 1));
    applyStimulus("auto_tog2",  23, mk(1, 1, 0, 1));
    applyStimulus("auto_tog3",  31, mk(0, 1, 0, 1));
    tick(8);  bus.KEY[2] = 1'b1;
    tick(1);  bus.KEY[1] = 1'b0;
    tick(6);  bus.KEY[1] = 1'b1;
    tick(17);

    // mode press landing on the terminal-count cycle leaves auto untoggled
    bus.KEY[2] = 1'b0;
    applyStimulus("term_pre",  6,  mk(0, 1, 0, 1));
    applyStimulus("term_exit", 7,  mk(0, 0, 0, 1));
    applyStimulus("man_stay",  15, mk(0, 0, 0, 1));
    tick(6);  bus.KEY[2] = 1'b1;
    tick(12);

    // simultaneous toggle and mode press: only the mode press applies
    bus.KEY[2:1] = 2'b00;
    applyStimulus("simul_pre",  6, mk(0, 0, 0, 1));
    applyStimulus("simul_mode", 7, mk(0, 1, 0, 1));
    applyStimulus("simul_hold", 9, mk(0, 1, 0, 1));
    tick(8);  bus.KEY[2:1] = 2'b11;
    tick(2);
`else
    // the mode button has no effect without auto support
    bus.KEY[2] = 1'b0;
    applyStimulus("mode_ignored", 7,  mk(1, 0, 0, 1));
    applyStimulus("mode_ignored2",15, mk(1, 0, 0, 1));
    tick(8);  bus.KEY[2] = 1'b1;
    tick(10);

    // simultaneous press: the toggle press applies
    bus.KEY[2:1] = 2'b00;
    applyStimulus("simul_pre",    6, mk(1, 0, 0, 1));
    applyStimulus("simul_toggle", 7, mk(0, 0, 0, 1));
    tick(8);  bus.KEY[2:1] = 2'b11;
    tick(2);
`endif

    // async reset takes effect before the next clock edge
    bus.KEY[0] = 1'b0;
    applyStimulus("async_reset", 0, mk(0, 0, 0, 0));
    tick(2);
    bus.KEY[0] = 1'b1;
    applyStimulus("reset_recover", 3,  mk(0, 0, 0, 1));
    applyStimulus("reset_manual",  12, mk(0, 0, 0, 1));
    tick(14);

    // a button held through reset must be released before it can press
    bus.KEY[1] = 1'b0;
    tick(2);
    bus.KEY[0] = 1'b0;
    tick(2);
    bus.KEY[0] = 1'b1;
    applyStimulus("held_through_reset", 16, mk(0, 0, 0, 1));
    tick(17);
    bus.KEY[1] = 1'b1;
    tick(10);
    bus.KEY[1] = 1'b0;
    applyStimulus("repress_early", DEB + 2, mk(0, 0, 0, 1));
    applyStimulus("repress_exact", DEB + 3, mk(1, 0, 0, 1));
    tick(10);
    bus.KEY[1] = 1'b1;

    for (int k = 0; k < 100 && sb.size() > 0; k++) tick(1);
    while (sb.size() > 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL %s: observed never checked, expected %h due cycle %0d",
             sb[0].tag, sb[0].val, sb[0].due);
      void'(sb.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux_sel_ctrl.md
MUX_SEL_CTRL -- requirements
Module: mux_sel_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the cycles of stable level required to accept a button change (10 ms at 50 MHz).
REQ-002 SHALL have parameter AUTO_PERIOD, default 25000000, giving the cycles between select toggles in auto mode (0.5 s at 50 MHz).
REQ-003 CLOCK_50  input  1  single system clock; all state rising-edge triggered.
REQ-004 KEY  input  4  KEY[0] = asynchronous active-low reset; KEY[1] = active-low select-toggle button; KEY[2] = active-low mode button; KEY[3] unused.
REQ-005 SW  input  10  SW[0] = data x; SW[1] = data y; SW[9:2] unused.
REQ-006 mux_s  output  1  registered select to the downstream 2:1 mux stage (0 selects x, 1 selects y).
REQ-007 mux_x, mux_y  output  1 each  registered data to the downstream mux.
REQ-008 LEDR  output  10  status: LEDR[9] = mux_s, LEDR[8] = auto mode, LEDR[1:0] = {mux_y, mux_x}, LEDR[7:2] = 0.

Function
REQ-009 KEY[1], KEY[2], SW[1:0] SHALL each pass through a 2-flop synchronizer before use.
REQ-010 Each synchronized button SHALL have a debouncer: the accepted level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count from 0.
REQ-011 A press SHALL be a 1-cycle pulse on the accepted level's 1->0 transition; releases generate nothing.
REQ-012 FSM states SHALL be MAN_S0, MAN_S1, AUTO_S0, AUTO_S1; mux_s = 1 in *_S1, auto flag = 1 in AUTO_*.
REQ-013 Toggle press in MAN_S0/MAN_S1 SHALL move to MAN_S1/MAN_S0; toggle press in AUTO_* SHALL be ignored.
REQ-014 Mode press SHALL swap MAN_Sn <-> AUTO_Sn while preserving n (mux_s unchanged).
REQ-015 Toggle and mode presses in the same cycle SHALL apply the mode press only; the toggle press is discarded.
REQ-016 In AUTO_*, a period counter SHALL count 0..AUTO_PERIOD-1, toggle S0<->S1 when it reaches AUTO_PERIOD-1 and wrap to 0; it SHALL be cleared to 0 on every entry to AUTO_* and held at 0 in MAN_*.
REQ-017 A mode press on the cycle the period counter is at terminal count SHALL leave auto without toggling mux_s.
REQ-018 Latency: a stable low on KEY[1] SHALL change mux_s exactly DEBOUNCE_CYCLES+3 cycles after the pin transition; SW[0]/SW[1] SHALL reach mux_x/mux_y in 3 cycles (2 sync + 1 output register).
REQ-019 Counter widths SHALL be sized by $clog2 of their parameter; no counter shall overflow for any parameter >= 2.

Reset
REQ-020 KEY[0] low SHALL asynchronously force state MAN_S0, all counters 0, synchronizers and accepted button levels 1 (released), mux_s/mux_x/mux_y 0, LEDR all 0.
REQ-021 Reset release SHALL be recognised on the next CLOCK_50 rising edge; a reset mid-debounce or mid-period SHALL discard the partial count and no press shall be emitted for a button held low through reset until it is released and pressed again.

Configuration
REQ-022 Macro MUX_SEL_AUTO_EN defined: auto mode, period counter and KEY[2] path SHALL be present as specified.
REQ-023 MUX_SEL_AUTO_EN undefined: AUTO_* states, period counter and KEY[2] debouncer SHALL be absent, KEY[2] ignored, LEDR[8] tied 0; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4, AUTO_PERIOD=8, macro defined unless noted)
REQ-024 Reset, SW[1:0]=2'b01 -> mux_x=1, mux_y=0 3 cycles after reset release; mux_s=0; LEDR=10'h001.
REQ-025 KEY[1] held low 10 cycles then released -> mux_s 0->1 exactly 7 cycles after the fall; LEDR[9]=1; release causes no change.
REQ-026 KEY[1] bounce low 2 / high 1 / low 2 cycles, then high -> mux_s stays 0.
REQ-027 Mode press from MAN_S1 -> LEDR[8]=1, mux_s stays 1, then toggles every 8 cycles (1,0,1...); toggle presses during auto leave the pattern unchanged.
REQ-028 KEY[1] and KEY[2] pressed in the same cycle from MAN_S0 -> AUTO_S0, mux_s=0; KEY[0] pulsed low mid-auto -> immediate MAN_S0, LEDR=0.
REQ-029 Macro undefined: KEY[2] presses -> LEDR[8]=0 and no state change; KEY[1] toggling behaves as in REQ-025.
